data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder that serves the load/store requests the main decoder raises through MemRead/MemWrite. It sits between the core's execute/memory stage and a word-organised RAM array, and applies a configurable access latency through an IDLE/ACCESS/RESP state machine. It supports RV32I byte, half and word loads and stores, with sign or zero extension on loads. It returns a stall (Busy), a one-cycle completion pulse (Ready) and an error flag for misaligned or unsupported accesses.

## Interface
- DEPTH_WORDS, 512: number of 32-bit words in the array; power of two.
- LATENCY, 2: number of cycles spent in ACCESS; legal range 1 to 15.
- clk, input, 1: single clock; all state updates on the rising edge.
- reset_n, input, 1: reset, asynchronous and active-low.
- MemRead, input, 1: load request from the decoder.
- MemWrite, input, 1: store request from the decoder.
- Funct3, input, 3: access size and sign, taken from instruction bits [14:12].
- Addr, input, 32: byte address (ALU result).
- WrData, input, 32: store data (register-file read data 2).
- RdData, output, 32: load result, registered.
- Ready, output, 1: one-cycle completion pulse.
- Busy, output, 1: stall request to the core.
- MisalignErr, output, 1: asserted together with Ready when the access was rejected.

## Operation
- States are IDLE, ACCESS and RESP.
- **Request acceptance (IDLE only):**
  - A request is accepted in IDLE when MemRead or MemWrite is high.
  - If both are high, the store wins and the read is discarded.
  - Addr, WrData, Funct3 and the read/write kind are captured into holding registers.
  - The state then moves to ACCESS and an internal counter loads LATENCY-1.
- **ACCESS:**
  - The counter decrements by one each cycle.
  - At count 0 the state moves to RESP.
  - On that same edge a valid store commits its byte enables to the array, and a valid load registers its extended result into RdData.
- **RESP:** Ready is 1 for one cycle, then the state returns to IDLE. Requests present during RESP are ignored; the core re-presents them in IDLE.
- **Loads:**
  - 000 lb: sign-extend byte.
  - 001 lh: sign-extend half.
  - 010 lw: full word.
  - 100 lbu: zero-extend byte.
  - 101 lhu: zero-extend half.
- **Stores:** 000 sb, 001 sh and 010 sw. The lane is chosen by Addr[1:0], and the byte enable is derived from size and offset.
- **Errors:**
  - Causes: half access with Addr[0]=1; word access with Addr[1:0]!=0; any other Funct3 value.
  - Effect: the access still takes full latency, but there is no array write and RdData is unchanged.
  - MisalignErr=1 alongside Ready.
- **Addressing:** word index = Addr[2 +: log2(DEPTH_WORDS)]. Upper address bits are ignored, so out-of-range addresses alias (wrap-around).
- **RdData:** updated only on completion of a valid load; it holds otherwise, including across stores.

## Timing
- **Reset:** reset_n low forces state IDLE, counter 0, and RdData, Ready, MisalignErr and holding registers all to 0. Busy is combinational and therefore 0 when no request is present. Array contents are not reset.
- **Busy:** = (IDLE & (MemRead | MemWrite)) | ACCESS. It is combinational from the request inputs in IDLE so that the core stalls in the request cycle.
- **Latency:** with the request in cycle 0, ACCESS occupies cycles 1 to LATENCY, and Ready/RdData/MisalignErr are valid in cycle LATENCY+1. Busy is 0 in the Ready cycle.
- **Throughput:** back-to-back requests are accepted at most every LATENCY+2 cycles.
- **Reset mid-operation:** a store that has not yet passed the ACCESS-to-RESP edge is dropped and the array is unchanged. No Ready pulse is issued after reset.
- **Input changes:** inputs changing during ACCESS have no effect, because all operands are taken from the holding registers.

## Structure
- **Package mem_pkg** holds:
  - the state enum (IDLE, ACCESS, RESP);
  - Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - a function for byte-enable generation;
  - a function for load extraction and extension.
- **Sub-module dmem_array:** DEPTH_WORDS x 32, synchronous write with 4 byte enables, combinational read. The responder instantiates it once.

## Test plan
- **Word round-trip:** reset; sw WrData=0xDEADBEEF to Addr=0x10, then lw from 0x10. Each access gives Ready in cycle 3 (LATENCY=2), and the load gives RdData=0xDEADBEEF, MisalignErr=0.
- **Byte/half extension:** with word 0x10 = 0x80FF7F01:
  - lb 0x13 gives 0xFFFFFF80.
  - lbu 0x13 gives 0x00000080.
  - lh 0x12 gives 0xFFFF80FF.
  - lhu 0x10 gives 0x00007F01.
- **Byte-lane store:** with word 0x20 = 0x11223344, sb 0xAA to 0x21; then lw 0x20 gives 0x1122AA44.
- **Misaligned and unsupported accesses:**
  - lw 0x22 gives MisalignErr=1 with Ready; RdData keeps its previous value.
  - sh 0x21 gives MisalignErr=1 and the array is unchanged.
  - Funct3=011 gives MisalignErr=1.
- **Simultaneous request and aliasing:**
  - MemRead=MemWrite=1, sw 0x5 to Addr 0x30: the store is performed.
  - Addr 0x30+4*DEPTH_WORDS aliases to the same word.
- **Reset mid-access:** issue sw 0x12345678 to 0x40 (word previously 0) and pull reset_n low in cycle 1. After release, lw 0x40 returns 0, and no Ready appears before the new request.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and access helpers for the data-memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the size/sign code exists for this access kind and the offset is naturally aligned
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] off,
                                       input logic is_write);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_write;
            F3_H:    ok = !off[0];
            F3_HU:   ok = !is_write && !off[0];
            F3_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by a store of the given size at the given offset
    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store operand across lanes so the byte enables alone pick the target
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] lanes;
        case (f3)
            F3_B:    lanes = {4{wd[7:0]}};
            F3_H:    lanes = {2{wd[15:0]}};
            default: lanes = wd;
        endcase
        return lanes;
    endfunction

    // Pull the addressed byte/half out of the word and sign- or zero-extend it
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {off, 3'b000};
        case (f3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = word;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-organised RAM, byte-enabled synchronous write, combinational read
module dmem_array #(
    parameter int DEPTH_WORDS = 512,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Write only the enabled lanes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - load/store responder with fixed access latency and misalignment detection
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Ready,
    output logic        Busy,
    output logic        MisalignErr
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    mem_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hold_addr_q, hold_addr_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    logic [2:0]  hold_f3_q, hold_f3_d;
    logic        hold_write_q, hold_write_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic          req_ok;
    logic          finish;
    logic          arr_we;
    logic [3:0]    arr_be;
    logic [31:0]   arr_wdata;
    logic [31:0]   arr_rdata;
    logic [AW-1:0] arr_addr;

    // Upper address bits only alias; they feed nothing
    logic unused_hold_addr;
    assign unused_hold_addr = ^hold_addr_q[31:AW+2];

    // Operands for the array come solely from the holding registers
    always_comb begin
        req_ok    = access_ok(hold_f3_q, hold_addr_q[1:0], hold_write_q);
        finish    = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
        arr_we    = finish && req_ok && hold_write_q;
        arr_be    = byte_enable(hold_f3_q, hold_addr_q[1:0]);
        arr_wdata = store_lanes(hold_f3_q, hold_wdata_q);
        arr_addr  = hold_addr_q[2 +: AW];
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Next-state, counter, capture and response computation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        hold_f3_d    = hold_f3_q;
        hold_write_d = hold_write_q;
        rd_data_d    = rd_data_q;
        ready_d      = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    hold_addr_d  = Addr;
                    hold_wdata_d = WrData;
                    hold_f3_d    = Funct3;
                    hold_write_d = MemWrite;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    err_d   = !req_ok;
                    if (req_ok && !hold_write_q) begin
                        rd_data_d = load_extract(arr_rdata, hold_f3_q, hold_addr_q[1:0]);
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and holding registers; reset abandons any in-flight access
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            hold_addr_q  <= 32'd0;
            hold_wdata_q <= 32'd0;
            hold_f3_q    <= 3'd0;
            hold_write_q <= 1'b0;
            rd_data_q    <= 32'd0;
            ready_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            hold_f3_q    <= hold_f3_d;
            hold_write_q <= hold_write_d;
            rd_data_q    <= rd_data_d;
            ready_q      <= ready_d;
            err_q        <= err_d;
        end
    end

    // Stall the core from the request cycle itself until the response cycle
    always_comb begin
        Busy = ((state_q == ST_IDLE) && (MemRead || MemWrite)) || (state_q == ST_ACCESS);
    end

    assign RdData      = rd_data_q;
    assign Ready       = ready_q;
    assign MisalignErr = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int DEPTH_WORDS = 512;
    localparam int LATENCY     = 2;

    logic        clk;
    logic        reset_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;
    logic        Ready;
    logic        Busy;
    logic        MisalignErr;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .Funct3      (Funct3),
        .Addr        (Addr),
        .WrData      (WrData),
        .RdData      (RdData),
        .Ready       (Ready),
        .Busy        (Busy),
        .MisalignErr (MisalignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Presents one request in an IDLE cycle and follows it to its Ready pulse
    task automatic mem_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] rdv, output logic errv,
                              output logic busy_req, output logic busy_rdy, output int lat);
        MemRead  = rd;
        MemWrite = wr;
        Funct3   = f3;
        Addr     = a;
        WrData   = wd;
        #1;
        busy_req = Busy;
        lat = 0;
        @(posedge clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Funct3   = 3'b111;
        Addr     = 32'hFFFF_FFFF;
        WrData   = 32'h5A5A_5A5A;
        lat = 1;
        while (!Ready && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdv      = RdData;
        errv     = MisalignErr;
        busy_rdy = Busy;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rdv;
    logic        ev;
    logic        bq;
    logic        br;
    int          lat;
    int          ready_seen;

    initial begin
        reset_n  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        Funct3   = 3'b000;
        Addr     = 32'd0;
        WrData   = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rddata", RdData, 32'h0);
        check("rst_ready", {31'd0, Ready}, 32'd0);
        check("rst_err", {31'd0, MisalignErr}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Word round-trip
        mem_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rdv, ev, bq, br, lat);
        check("sw_lat", 32'(lat), 32'(LATENCY + 1));
        check("sw_busy_req", {31'd0, bq}, 32'd1);
        check("sw_err", {31'd0, ev}, 32'd0);
        mem_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rdv, ev, bq, br, lat);
        check("lw_lat", 32'(lat), 32'(LATENCY + 1));
        check("lw_data", rdv, 32'hDEADBEEF);
        check("lw_err", {31'd0, ev}, 32'd0);
        check("lw_busy_rdy", {31'd0, br}, 32'd0);

        // Byte/half extension
        mem_access(1'b0, 1'b1, 3'b010, 32'h10, 32'h80FF7F01, rdv, ev, bq, br, lat);
        mem_access(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, rdv, ev, bq, br, lat);
        check("lb_13", rdv, 32'hFFFFFF80);
        mem_access(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, rdv, ev, bq, br, lat);
        check("lbu_13", rdv, 32'h00000080);
        mem_access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, rdv, ev, bq, br, lat);
        check("lh_12", rdv, 32'hFFFF80FF);
        mem_access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, rdv, ev, bq, br, lat);
        check("lhu_10", rdv, 32'h00007F01);
        mem_access(1'b1, 1'b0, 3'b000, 32'h10, 32'h0, rdv, ev, bq, br, lat);
        check("lb_10", rdv, 32'h00000001);

        // Byte-lane store
        mem_access(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, rdv, ev, bq, br, lat);
        mem_access(1'b0, 1'b1, 3'b000, 32'h21, 32'h000000AA, rdv, ev, bq, br, lat);
        check("sb_err", {31'd0, ev}, 32'd0);
        mem_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rdv, ev, bq, br, lat);
        check("sb_lw_20", rdv, 32'h1122AA44);
        mem_access(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000BEEF, rdv, ev, bq, br, lat);
        mem_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rdv, ev, bq, br, lat);
        check("sh_lw_20", rdv, 32'hBEEFAA44);

        // Misaligned and unsupported accesses
        mem_access(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, rdv, ev, bq, br, lat);
        check("lw22_err", {31'd0, ev}, 32'd1);
        check("lw22_lat", 32'(lat), 32'(LATENCY + 1));
        check("lw22_hold", rdv, 32'hBEEFAA44);
        mem_access(1'b0, 1'b1, 3'b001, 32'h21, 32'h00001234, rdv, ev, bq, br, lat);
        check("sh21_err", {31'd0, ev}, 32'd1);
        mem_access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rdv, ev, bq, br, lat);
        check("sh21_nowr", rdv, 32'hBEEFAA44);
        check("lw20_err", {31'd0, ev}, 32'd0);
        mem_access(1'b1, 1'b0, 3'b011, 32'h20, 32'h0, rdv, ev, bq, br, lat);
        check("f3_011_err", {31'd0, ev}, 32'd1);
        check("f3_011_hold", rdv, 32'hBEEFAA44);

        // Simultaneous request and aliasing
        mem_access(1'b1, 1'b1, 3'b010, 32'h30, 32'h00000005, rdv, ev, bq, br, lat);
        check("both_hold", rdv, 32'hBEEFAA44);
        mem_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rdv, ev, bq, br, lat);
        check("both_store", rdv, 32'h00000005);
        mem_access(1'b1, 1'b0, 3'b010, 32'h30 + 4 * DEPTH_WORDS, 32'h0, rdv, ev, bq, br, lat);
        check("alias_rd", rdv, 32'h00000005);
        mem_access(1'b0, 1'b1, 3'b010, 32'h8000_0030, 32'h00000077, rdv, ev, bq, br, lat);
        mem_access(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, rdv, ev, bq, br, lat);
        check("alias_wr", rdv, 32'h00000077);

        // Reset mid-access
        mem_access(1'b0, 1'b1, 3'b010, 32'h40, 32'h0, rdv, ev, bq, br, lat);
        MemWrite = 1'b1;
        Funct3   = 3'b010;
        Addr     = 32'h40;
        WrData   = 32'h12345678;
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midrst_busy", {31'd0, Busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_rddata", RdData, 32'h0);
        reset_n = 1'b1;
        ready_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (Ready) ready_seen++;
        end
        check("midrst_no_ready", 32'(ready_seen), 32'd0);
        mem_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rdv, ev, bq, br, lat);
        check("midrst_lat", 32'(lat), 32'(LATENCY + 1));
        check("midrst_lw", rdv, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
